// File: rtl/ram_dw_arb_pkg.sv
// Shared types and helpers for the round-robin RAM arbiter.
package ram_dw_arb_pkg;

    localparam int unsigned NREQ_MAX = 8;

    typedef logic [2:0] req_idx_t;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // Pointer value following ptr in a ring of nreq requesters.
    function automatic req_idx_t rr_next(input req_idx_t ptr, input int unsigned nreq);
        return (ptr == req_idx_t'(nreq - 1)) ? '0 : ptr + 3'd1;
    endfunction

endpackage

// File: rtl/ram_dw_arb_rr_arbiter.sv
// Round-robin arbiter: searches elig upward from ptr, wraps modulo NREQ, owns ptr.
module rr_arbiter
    import ram_dw_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] elig_i,
    output logic [NREQ-1:0] grant_o,
    output req_idx_t        win_o,
    output logic            any_o
);

    localparam logic [3:0] NREQ_L = 4'(NREQ);

    req_idx_t   ptr_q, ptr_d;
    logic [3:0] pos;

    // First eligible index at or after ptr wins.
    always_comb begin
        grant_o = '0;
        win_o   = '0;
        any_o   = 1'b0;
        pos     = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, ptr_q} + 4'(k);
            if (pos >= NREQ_L) begin
                pos = pos - NREQ_L;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!any_o && pos == 4'(i) && elig_i[i]) begin
                    any_o      = 1'b1;
                    grant_o[i] = 1'b1;
                    win_o      = req_idx_t'(i);
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (any_o) begin
            ptr_d = rr_next(win_o, NREQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_dw_arb.sv
// Shares one two-word register RAM between NREQ requesters with per-requester response slots.
// Optional per-requester grant counters: define RAM_DW_ARB_STATS_EN.
module ram_dw_arb
    import ram_dw_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREQ  = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_we,
    input  logic [NREQ-1:0]       req_addr,
    input  logic [NREQ*WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [NREQ*WIDTH-1:0] rsp_data,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic                  ram_addr,
    output logic                  ram_st,
    output logic [WIDTH-1:0]      ram_x,
    input  logic [WIDTH-1:0]      ram_out
`ifdef RAM_DW_ARB_STATS_EN
    ,
    output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

    if (NREQ < 2 || NREQ > NREQ_MAX || CNT_W < 1) begin : g_bad_param
        $error("ram_dw_arb: NREQ must be 2..8 and CNT_W at least 1");
    end

    logic [NREQ-1:0]     elig;
    logic [NREQ-1:0]     grant;
    req_idx_t            win;
    logic                any_grant;
    logic [NREQ_MAX-1:0] addr_ext, we_ext;
    logic [WIDTH-1:0]    wdata_a [NREQ_MAX];

    rsp_state_e             rsp_st_q [NREQ];
    rsp_state_e             rsp_st_d [NREQ];
    logic [NREQ*WIDTH-1:0]  rsp_data_q, rsp_data_d;

    // Writes ignore the slot; reads need a free or draining slot. Nothing is granted in reset.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i] && !rst &&
                      (req_we[i] || rsp_st_q[i] == RSP_EMPTY || rsp_ready[i]);
        end
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .elig_i  (elig),
        .grant_o (grant),
        .win_o   (win),
        .any_o   (any_grant)
    );

    assign req_ready = grant;

    always_comb begin
        addr_ext = NREQ_MAX'(req_addr);
        we_ext   = NREQ_MAX'(req_we);
        for (int i = 0; i < NREQ_MAX; i++) begin
            wdata_a[i] = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            wdata_a[i] = req_wdata[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        ram_addr = 1'b0;
        ram_st   = 1'b0;
        ram_x    = '0;
        if (any_grant) begin
            ram_addr = addr_ext[win];
            ram_st   = we_ext[win];
            ram_x    = wdata_a[win];
        end
    end

    // Response slot: a read grant fills (or refills) it, rsp_ready without a refill empties it.
    always_comb begin
        rsp_data_d = rsp_data_q;
        for (int i = 0; i < NREQ; i++) begin
            rsp_st_d[i] = rsp_st_q[i];
            if (grant[i] && !req_we[i]) begin
                rsp_st_d[i]                   = RSP_FULL;
                rsp_data_d[i*WIDTH +: WIDTH] = ram_out;
            end else if (rsp_st_q[i] == RSP_FULL && rsp_ready[i]) begin
                rsp_st_d[i] = RSP_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                rsp_st_q[i] <= RSP_EMPTY;
            end
            rsp_data_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                rsp_st_q[i] <= rsp_st_d[i];
            end
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = (rsp_st_q[i] == RSP_FULL);
        end
    end

    assign rsp_data = rsp_data_q;

`ifdef RAM_DW_ARB_STATS_EN
    logic [NREQ*CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of accepted accesses per requester.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i] && cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
                cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule
